// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider for the EX stage.
// Runs DIV/DIVU over WIDTH iterations and requests a pipeline stall until
// the {remainder, quotient} pair is ready for the HI/LO write path.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]     r_rem, w_rem_nxt;
    logic [WIDTH-1:0]     r_quo, w_quo_nxt;
    logic [WIDTH-1:0]     r_dvs, w_dvs_nxt;
    logic                 r_neg_q, w_neg_q_nxt;
    logic                 r_neg_r, w_neg_r_nxt;
    logic [2*WIDTH-1:0]   r_result, w_result_nxt;
    logic                 r_ready, w_ready_nxt;

    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH-1:0]     w_quo_sh;
    logic [WIDTH-1:0]     w_sub;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_step_rem;
    logic [WIDTH-1:0]     w_step_quo;

    // Two's complement negate when 'neg' is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Magnitude of an operand; raw value for unsigned divides.
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return f_cond_neg(v, sgn & v[WIDTH-1]);
    endfunction

    // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
    // If the shifted-out bit is set the partial remainder already exceeds any
    // WIDTH-bit divisor, and the true difference still fits in WIDTH bits.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_quo_sh = {r_quo[WIDTH-2:0], 1'b0};
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_dvs;
    assign w_ge     = w_rem_sh[WIDTH] | (w_rem_sh[WIDTH-1:0] >= r_dvs);

    // Commit or restore the trial subtraction.
    always_comb begin
        if (w_ge) begin
            w_step_rem = w_sub;
            w_step_quo = w_quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_step_rem = w_rem_sh[WIDTH-1:0];
            w_step_quo = w_quo_sh;
        end
    end

    // Next-state and datapath update; annul overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_dvs_nxt    = r_dvs;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
        if (annul_i) begin
            w_state_nxt  = S_IDLE;
            w_ready_nxt  = 1'b0;
            w_result_nxt = {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = {(2*WIDTH){1'b0}};
                    if (start_i) begin
                        if (opdata2_i == {WIDTH{1'b0}}) begin
                            w_state_nxt = S_BYZERO;
                        end else begin
                            w_state_nxt = S_ON;
                            w_quo_nxt   = f_mag(opdata1_i, signed_i);
                            w_dvs_nxt   = f_mag(opdata2_i, signed_i);
                            w_rem_nxt   = {WIDTH{1'b0}};
                            w_cnt_nxt   = {CW{1'b0}};
                            w_neg_q_nxt = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            w_neg_r_nxt = signed_i & opdata1_i[WIDTH-1];
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BYZERO: begin
                    w_state_nxt  = S_END;
                    w_ready_nxt  = 1'b1;
                    w_result_nxt = {(2*WIDTH){1'b0}};
                end
                S_ON: begin
                    w_rem_nxt = w_step_rem;
                    w_quo_nxt = w_step_quo;
                    w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_state_nxt  = S_END;
                        w_ready_nxt  = 1'b1;
                        w_result_nxt = {f_cond_neg(w_step_rem, r_neg_r),
                                        f_cond_neg(w_step_quo, r_neg_q)};
                    end else begin
                        w_state_nxt = S_ON;
                    end
                end
                S_END: begin
                    if (start_i) begin
                        w_state_nxt = S_END;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_ready_nxt  = 1'b0;
                        w_result_nxt = {(2*WIDTH){1'b0}};
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = {(2*WIDTH){1'b0}};
                end
            endcase
        end
    end

    // State, iteration counter, operand latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
            r_dvs    <= {WIDTH{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= {(2*WIDTH){1'b0}};
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_dvs    <= w_dvs_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    // Stall until the result is ready so the pipeline advances exactly once with it.
    assign stallreq_o = start_i & ~annul_i & ~r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corners plus randomized divides
// checked against a plain-arithmetic reference model.
module tb_div_iter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           signed_i;
    logic           annul_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           stallreq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .annul_i    (annul_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: integer division truncating toward zero, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        q32 = q[31:0];
        r32 = r[31:0];
        return {r32, q32};
    endfunction

    // Issue one divide, measure latency, watch the stall, hold one cycle, then release.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input bit scramble, input logic [63:0] exp);
        int  lat;
        int  exp_lat;
        bit  stall_ok;
        exp_lat = (b == 32'd0) ? 2 : W + 1;
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        stall_ok = stallreq_o;
        lat = 0;
        while (!ready_o && lat < W + 8) begin
            @(negedge clk);
            lat++;
            if (!ready_o) begin
                if (!stallreq_o) stall_ok = 1'b0;
                if (scramble) begin
                    opdata1_i = $urandom;
                    opdata2_i = $urandom;
                end
            end
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_stall"}, 64'(stall_ok), 64'd1);
        check_val({tag, "_res"}, result_o, exp);
        check_val({tag, "_stall_end"}, 64'(stallreq_o), 64'd0);
        @(negedge clk);
        check_val({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        check_val({tag, "_hold_res"}, result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        check_val({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        check_val({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        bit          saw_ready;
        int          n;

        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        #12;
        check_val("rst_rdy", 64'(ready_o), 64'd0);
        check_val("rst_res", result_o, 64'd0);
        check_val("rst_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-derived expectations.
        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, {32'd2, 32'd14});
        run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, {32'h00000001, 32'hFFFFFFFD});
        run_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, {32'd0, 32'h80000000});
        run_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, {32'd0, 32'hFFFFFFFF});
        run_div("divu_5_9", 32'd5, 32'd9, 1'b0, 1'b0, {32'd5, 32'd0});
        run_div("div_by_zero", 32'd1234, 32'd0, 1'b1, 1'b0, 64'd0);

        // Annul mid-divide: never ready, no stall while annulled, then a fresh divide.
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        saw_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        annul_i = 1'b1;
        #1;
        check_val("annul_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        if (ready_o) saw_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        check_val("annul_never_ready", 64'(saw_ready), 64'd0);
        run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 1'b0, {32'd0, 32'd3});

        // Async reset while a result is presented: outputs clear between edges.
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        n = 0;
        while (!ready_o && n < W + 8) begin
            @(negedge clk);
            n++;
        end
        check_val("end_rdy_before_rst", 64'(ready_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rst_end_rdy", 64'(ready_o), 64'd0);
        check_val("rst_end_res", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-ON, then a fresh divide with full latency.
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst_on_rdy", 64'(ready_o), 64'd0);
        check_val("rst_on_res", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst_100_7", 32'd100, 32'd7, 1'b0, 1'b0, {32'd2, 32'd14});

        // Randomized divides against the reference model, operands scrambled during ON.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(3, 0))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15, 1));
                2: b = {{16{1'b1}}, 16'($urandom)};
                default: b = $urandom;
            endcase
            if ($urandom_range(7, 0) == 0) a = 32'h80000000;
            s = 1'($urandom_range(1, 0));
            run_div("rand", a, b, s, 1'b1, ref_div(a, b, s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
